fpu_div_pack: RTL and testbench
===============================

Name: fpu_div_pack

Overview:
Consumer end of the FPU divider result interface. It accepts the raw 27-bit quotient, biased exponent, sign and destination register from the iterative divider. It normalises, rounds and packs these into an IEEE-754 single-precision word. Results are buffered in a 2-entry FIFO and presented to the register-file writeback arbiter with a valid/ready handshake. The block also gives the issue logic a busy indication.

Parameters:
FIFO_DEPTH, 2, output buffer entries (power of two, at least 2).

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
div_valid  input  1  one-cycle pulse: quotient fields valid this cycle
div_mantissa  input  27  quotient; bit25 weight 1.0, bits24:0 fractional, bit26 ignored
div_exponent  input  8  biased exponent (exp_a - exp_b + 127, modulo 256)
div_sign  input  1  result sign
div_dest  input  5  destination register
wb_valid  output  1  packed result available (FIFO non-empty)
wb_ready  input  1  writeback arbiter accepts head entry this cycle
wb_data  output  32  packed IEEE single result
wb_dest  output  5  destination register of head entry
div_busy  output  1  stage register valid OR FIFO non-empty; issue must not start a new divide while high
pack_overflow  output  1  sticky error; set when a result is lost

Behaviour:
- Reset (async, reset_n low): stage valid=0, FIFO empty, wb_valid=0, wb_data=0, wb_dest=0, div_busy=0, pack_overflow=0. Assertion mid-operation discards all in-flight results.
- Stage 1 (registered on the edge sampling div_valid=1):
  - If div_mantissa[25]=1: sig24=mant[25:2], guard=mant[1], adj=0.
  - Otherwise: sig24=mant[24:1], guard=mant[0], adj=1.
  - Rounding is round-half-up: sig25 = sig24 + guard.
  - 9-bit exponent: e9 = {1'b0,div_exponent} - adj + sig25[24].
  - Fraction = sig25[24] ? 23'd0 : sig25[22:0].
- Stage 1 special cases, in priority order:
  - div_mantissa[25:24]==0 (zero dividend) -> {sign,31'b0}.
  - e9==0 or e9[8]=1 (underflow or wrap) -> signed zero (flush).
  - e9>=255 -> {sign,8'hFF,23'b0} (infinity).
  - Else -> {sign,e9[7:0],fraction}.
- Stage 2: the stage-1 result is written into the FIFO on the next edge.
  - Latency: div_valid at edge k -> wb_valid high after edge k+1 when the FIFO was empty.
- FIFO:
  - Head drives wb_data/wb_dest.
  - A pop occurs when wb_valid && wb_ready.
  - Push and pop in the same cycle are legal, including when full; occupancy is unchanged.
  - Push when full without a pop: the new entry is dropped and pack_overflow sets. It clears only on reset.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- div_valid while the stage register is already valid is legal: the stage register pipelines one result per cycle.
- wb_data/wb_dest hold their value while wb_valid && !wb_ready.

Optional Feature:
FPU_DIV_PACK_INEXACT_EN
- Defined: adds output port wb_inexact (1 bit).
  - Stored per FIFO entry; set when guard=1 or when a flush or overflow special case was taken.
  - Reset value 0.
- Undefined: the port and its FIFO storage are absent; all other behaviour is identical.

Test Plan:
- 6.0/2.0: div_mantissa=27'h3000000, exp=8'h80, sign=0, dest=3; wb_ready=1 -> wb_valid 2 cycles later, wb_data=32'h40400000, wb_dest=3, single cycle.
- 1.0/1.5: mant=27'h1555555, exp=8'h7F -> wb_data=32'h3F2AAAAB (shift plus round-up); with FPU_DIV_PACK_INEXACT_EN, wb_inexact=1.
- Round carry: mant=27'h3FFFFFE, exp=8'h7F, sign=1 -> wb_data=32'hC0000000.
- Specials:
  - mant=0, sign=1 -> 32'h80000000.
  - mant=27'h1000000, exp=8'h01 -> 32'h00000000.
  - mant=27'h3FFFFFE, exp=8'hFE -> 32'h7F800000.
- Backpressure: wb_ready=0, issue 3 results on consecutive cycles.
  - The first two are held in order and the third is dropped with pack_overflow=1.
  - Raising wb_ready drains the two entries in order; div_busy falls the cycle after the last pop.
- Reset mid-operation: assert reset_n=0 with the stage register valid and the FIFO holding 1 entry -> all outputs 0 immediately; no wb_valid after release.

Source files
------------

// File: rtl/fpu_div_pack.sv
// Divider result packer: normalise, round-half-up and pack the raw quotient into an IEEE-754
// single, then buffer it in a small FIFO for writeback. Optional macro: FPU_DIV_PACK_INEXACT_EN.
module fpu_div_pack #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        div_valid,
    input  logic [26:0] div_mantissa,
    input  logic [7:0]  div_exponent,
    input  logic        div_sign,
    input  logic [4:0]  div_dest,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        div_busy,
`ifdef FPU_DIV_PACK_INEXACT_EN
    output logic        wb_inexact,
`endif
    output logic        pack_overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Stage-1 combinational normalise / round / pack
    logic [23:0] sig24;
    logic        guard;
    logic        adj;
    logic [24:0] sig25;
    logic [8:0]  e9;
    logic [22:0] frac;
    logic        is_zero;
    logic        is_flush;
    logic        is_inf;
    logic [31:0] packed_word;
    logic [1:0]  unused_bits;

    always_comb begin
        sig24 = div_mantissa[24:1];
        guard = div_mantissa[0];
        adj   = 1'b1;
        if (div_mantissa[25]) begin
            sig24 = div_mantissa[25:2];
            guard = div_mantissa[1];
            adj   = 1'b0;
        end
        sig25    = {1'b0, sig24} + {24'd0, guard};
        e9       = {1'b0, div_exponent} - {8'd0, adj} + {8'd0, sig25[24]};
        frac     = sig25[24] ? 23'd0 : sig25[22:0];
        is_zero  = (div_mantissa[25:24] == 2'b00);
        is_flush = (e9 == 9'd0) || e9[8];
        is_inf   = (e9 >= 9'd255);
        if (is_zero || is_flush)
            packed_word = {div_sign, 31'd0};
        else if (is_inf)
            packed_word = {div_sign, 8'hFF, 23'd0};
        else
            packed_word = {div_sign, e9[7:0], frac};
    end

    // Bit 26 of the quotient and the implicit leading one never reach the packed word.
    assign unused_bits = {div_mantissa[26], sig25[23]};

`ifdef FPU_DIV_PACK_INEXACT_EN
    logic inexact_calc;
    assign inexact_calc = guard || (!is_zero && (is_flush || is_inf));
`endif

    // Stage register
    logic        stg_valid;
    logic [31:0] stg_data;
    logic [4:0]  stg_dest;
`ifdef FPU_DIV_PACK_INEXACT_EN
    logic        stg_inexact;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid   <= 1'b0;
            stg_data    <= '0;
            stg_dest    <= '0;
`ifdef FPU_DIV_PACK_INEXACT_EN
            stg_inexact <= 1'b0;
`endif
        end else begin
            stg_valid <= div_valid;
            if (div_valid) begin
                stg_data    <= packed_word;
                stg_dest    <= div_dest;
`ifdef FPU_DIV_PACK_INEXACT_EN
                stg_inexact <= inexact_calc;
`endif
            end
        end
    end

    // Writeback handshake: the head entry transfers on any edge where wb_valid && wb_ready;
    // wb_valid never depends on wb_ready, and the head is stable until it transfers.
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [4:0]    mem_dest [FIFO_DEPTH];
`ifdef FPU_DIV_PACK_INEXACT_EN
    logic          mem_inexact [FIFO_DEPTH];
`endif
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          do_write;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = wb_valid && wb_ready;
    assign do_write = stg_valid && (!full || pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            pack_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i]    <= '0;
                mem_dest[i]    <= '0;
`ifdef FPU_DIV_PACK_INEXACT_EN
                mem_inexact[i] <= 1'b0;
`endif
            end
        end else begin
            if (do_write) begin
                mem_data[wr_ptr]    <= stg_data;
                mem_dest[wr_ptr]    <= stg_dest;
`ifdef FPU_DIV_PACK_INEXACT_EN
                mem_inexact[wr_ptr] <= stg_inexact;
`endif
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_write && !pop)
                count <= count + CW'(1);
            else if (!do_write && pop)
                count <= count - CW'(1);
            if (stg_valid && !do_write)
                pack_overflow <= 1'b1;
        end
    end

    // Outputs read as zero whenever the FIFO is empty so stale entries never leak out.
    assign wb_valid   = (count != '0);
    assign wb_data    = wb_valid ? mem_data[rd_ptr] : 32'd0;
    assign wb_dest    = wb_valid ? mem_dest[rd_ptr] : 5'd0;
`ifdef FPU_DIV_PACK_INEXACT_EN
    assign wb_inexact = wb_valid ? mem_inexact[rd_ptr] : 1'b0;
`endif
    assign div_busy   = stg_valid || wb_valid;

endmodule

// File: tb/tb_fpu_div_pack.sv
// Directed bench for fpu_div_pack: packing cases, specials, backpressure/overflow and
// mid-operation reset, each checked against hand-computed IEEE-754 words.
module tb_fpu_div_pack;

    logic        clock;
    logic        reset_n;
    logic        div_valid;
    logic [26:0] div_mantissa;
    logic [7:0]  div_exponent;
    logic        div_sign;
    logic [4:0]  div_dest;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        div_busy;
    logic        pack_overflow;
`ifdef FPU_DIV_PACK_INEXACT_EN
    logic        wb_inexact;
`endif

    int checks = 0;
    int errors = 0;

    fpu_div_pack #(.FIFO_DEPTH(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .div_valid     (div_valid),
        .div_mantissa  (div_mantissa),
        .div_exponent  (div_exponent),
        .div_sign      (div_sign),
        .div_dest      (div_dest),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_dest       (wb_dest),
        .div_busy      (div_busy),
`ifdef FPU_DIV_PACK_INEXACT_EN
        .wb_inexact    (wb_inexact),
`endif
        .pack_overflow (pack_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [26:0] m, input logic [7:0] e, input logic s, input logic [4:0] d);
        div_valid    = 1'b1;
        div_mantissa = m;
        div_exponent = e;
        div_sign     = s;
        div_dest     = d;
    endtask

    // One isolated result with wb_ready high: visible for exactly one cycle, two edges after issue.
    task automatic run_one(input string tag, input logic [26:0] m, input logic [7:0] e,
                           input logic s, input logic [4:0] d, input logic [31:0] exp_data,
                           input logic exp_inexact);
        drive(m, e, s, d);
        step();
        div_valid = 1'b0;
        check({tag, "_busy_stage"}, {31'd0, div_busy}, 32'd1);
        check({tag, "_valid_early"}, {31'd0, wb_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_dest"}, {27'd0, wb_dest}, {27'd0, d});
`ifdef FPU_DIV_PACK_INEXACT_EN
        check({tag, "_inexact"}, {31'd0, wb_inexact}, {31'd0, exp_inexact});
`else
        if (exp_inexact === 1'bx) checks++;
`endif
        step();
        check({tag, "_valid_after"}, {31'd0, wb_valid}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, div_busy}, 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        div_valid    = 1'b0;
        div_mantissa = '0;
        div_exponent = '0;
        div_sign     = 1'b0;
        div_dest     = '0;
        wb_ready     = 1'b1;
        repeat (3) step();
        check("rst_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_dest", {27'd0, wb_dest}, 32'd0);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_ovf", {31'd0, pack_overflow}, 32'd0);
        reset_n = 1'b1;
        step();

        run_one("six_div_two", 27'h3000000, 8'h80, 1'b0, 5'd3, 32'h40400000, 1'b0);
        run_one("one_div_1p5", 27'h1555555, 8'h7F, 1'b0, 5'd7, 32'h3F2AAAAB, 1'b1);
        run_one("round_carry", 27'h3FFFFFE, 8'h7F, 1'b1, 5'd9, 32'hC0000000, 1'b1);
        run_one("zero_div", 27'h0000000, 8'h55, 1'b1, 5'd4, 32'h80000000, 1'b0);
        run_one("flush", 27'h1000000, 8'h01, 1'b0, 5'd5, 32'h00000000, 1'b1);
        run_one("inf", 27'h3FFFFFE, 8'hFE, 1'b0, 5'd6, 32'h7F800000, 1'b1);
        run_one("wrap_flush", 27'h1000000, 8'h00, 1'b1, 5'd8, 32'h80000000, 1'b1);

        // Backpressure: three back-to-back results, only two fit
        wb_ready = 1'b0;
        drive(27'h3000000, 8'h80, 1'b0, 5'd1);
        step();
        drive(27'h1555555, 8'h7F, 1'b0, 5'd2);
        step();
        drive(27'h3FFFFFE, 8'h7F, 1'b1, 5'd3);
        step();
        div_valid = 1'b0;
        check("bp_ovf_before_drop", {31'd0, pack_overflow}, 32'd0);
        step();
        check("bp_ovf", {31'd0, pack_overflow}, 32'd1);
        check("bp_head_data", wb_data, 32'h40400000);
        check("bp_head_dest", {27'd0, wb_dest}, 32'd1);
        step();
        check("bp_hold_data", wb_data, 32'h40400000);
        check("bp_hold_valid", {31'd0, wb_valid}, 32'd1);
        wb_ready = 1'b1;
        step();
        check("bp_second_data", wb_data, 32'h3F2AAAAB);
        check("bp_second_dest", {27'd0, wb_dest}, 32'd2);
        check("bp_busy_mid", {31'd0, div_busy}, 32'd1);
        step();
        check("bp_drained_valid", {31'd0, wb_valid}, 32'd0);
        check("bp_drained_busy", {31'd0, div_busy}, 32'd0);
        check("bp_ovf_sticky", {31'd0, pack_overflow}, 32'd1);

        // Reset with one entry in the FIFO and another in the stage register
        wb_ready = 1'b0;
        drive(27'h3000000, 8'h80, 1'b0, 5'd10);
        step();
        drive(27'h1555555, 8'h7F, 1'b0, 5'd11);
        step();
        div_valid = 1'b0;
        check("mid_valid_pre", {31'd0, wb_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, wb_valid}, 32'd0);
        check("mid_rst_data", wb_data, 32'd0);
        check("mid_rst_dest", {27'd0, wb_dest}, 32'd0);
        check("mid_rst_busy", {31'd0, div_busy}, 32'd0);
        check("mid_rst_ovf", {31'd0, pack_overflow}, 32'd0);
        step();
        reset_n  = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_valid", {31'd0, wb_valid}, 32'd0);
        end

        run_one("after_reset", 27'h3000000, 8'h81, 1'b1, 5'd31, 32'hC0C00000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
